// File: rtl/fsm_arb_pkg.sv
// fsm_arb_pkg: shared types and constants for the recogniser-sharing arbiter.
`default_nettype none

package fsm_arb_pkg;

   localparam int SYM_W = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      STREAM = 2'd2,
      REPORT = 2'd3
   } arb_state_t;

   // Requester 0 gets first pick after reset because the search starts at last_grant+1.
   function automatic int last_grant_rst(input int nreq);
      return nreq - 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first valid requester after last_grant.
`default_nettype none

module rr_picker #(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  req_valid,
   input  logic [IDX_W-1:0] last_grant,
   output logic [NREQ-1:0]  onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int cand;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      cand   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(last_grant) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         for (int i = 0; i < NREQ; i++) begin
            if (!any && (cand == i) && req_valid[i]) begin
               any       = 1'b1;
               onehot[i] = 1'b1;
               idx       = IDX_W'(i);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fsm_abb_arbiter.sv
// fsm_abb_arbiter: round-robin owner of one shared Mealy recogniser, counting matches per packet.
// Optional stall abort enabled by defining FSM_ARB_TIMEOUT_EN.
`default_nettype none

module fsm_abb_arbiter
   import fsm_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [2*NREQ-1:0]         req_sym,
   input  logic [NREQ-1:0]           req_last,
   output logic [NREQ-1:0]           req_ready,
   output logic [NREQ-1:0]           grant,
   output logic [SYM_W-1:0]          rec_sym,
   output logic                      rec_en,
   output logic                      rec_clear,
   input  logic                      rec_match,
   output logic                      done,
   output logic [$clog2(NREQ)-1:0]   done_id,
   output logic [CNT_W-1:0]          done_count,
   output logic                      done_abort
);

   localparam int IDX_W = $clog2(NREQ);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(last_grant_rst(NREQ));
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   arb_state_t       state, state_nxt;
   logic [NREQ-1:0]  grant_q;
   logic [IDX_W-1:0] gidx, last_grant;
   logic [CNT_W-1:0] count, count_nxt;
   logic [NREQ-1:0]  pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             beat, timeout_hit;
   logic             valid_g, last_g;
   logic [SYM_W-1:0] sym_g;

   rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .onehot     (pick_oh),
      .idx        (pick_idx),
      .any        (pick_any)
   );

   always_comb begin
      valid_g = 1'b0;
      last_g  = 1'b0;
      sym_g   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gidx == IDX_W'(i)) begin
            valid_g = req_valid[i];
            last_g  = req_last[i];
            sym_g   = req_sym[i*SYM_W +: SYM_W];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      beat      = 1'b0;
      req_ready = '0;
      rec_en    = 1'b0;
      rec_clear = 1'b0;
      rec_sym   = '0;
      done      = 1'b0;
      unique case (state)
         IDLE:   if (pick_any) state_nxt = CLEAR;
         CLEAR: begin
            rec_clear = 1'b1;
            state_nxt = STREAM;
         end
         STREAM: begin
            req_ready = grant_q;
            rec_sym   = sym_g;
            beat      = valid_g;
            rec_en    = beat;
            if ((beat && last_g) || timeout_hit) state_nxt = REPORT;
         end
         REPORT: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign count_nxt = (beat && rec_match && (count != CNT_MAX)) ? count + CNT_W'(1) : count;
   assign grant     = grant_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant_q    <= '0;
         gidx       <= '0;
         last_grant <= LAST_RST;
         count      <= '0;
         done_id    <= '0;
         done_count <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  grant_q <= pick_oh;
                  gidx    <= pick_idx;
               end
            end
            CLEAR:  count <= '0;
            STREAM: begin
               count <= count_nxt;
               // Report registers load on the way into REPORT so the last-beat match is included.
               if (state_nxt == REPORT) begin
                  done_id    <= gidx;
                  done_count <= count_nxt;
               end
            end
            REPORT: begin
               last_grant <= gidx;
               grant_q    <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef FSM_ARB_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT + 1);

   logic [STALL_W-1:0] stall;
   logic               abort_q;

   assign timeout_hit = (state == STREAM) && !beat && (stall == STALL_W'(TIMEOUT - 1));
   assign done_abort  = abort_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stall   <= '0;
         abort_q <= 1'b0;
      end else begin
         if (state == CLEAR || beat) stall <= '0;
         else if (state == STREAM)   stall <= stall + STALL_W'(1);
         if (state == STREAM && state_nxt == REPORT) abort_q <= !(beat && last_g);
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT > 0);
   assign timeout_hit    = 1'b0;
   assign done_abort     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsm_abb_arbiter.sv
// tb_fsm_abb_arbiter: directed vectors against a bench-side enable/clear recogniser model.
`default_nettype none

module tb_fsm_abb_arbiter;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [1:0] req_valid, req_last, req_ready, grant, rec_sym;
   logic [3:0] req_sym;
   logic       rec_en, rec_clear, rec_match, done, done_abort;
   logic [0:0] done_id;
   logic [1:0] done_count;

   int n_cmp = 0;
   int n_err = 0;

   fsm_abb_arbiter #(.NREQ(2), .CNT_W(2), .TIMEOUT(4)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_sym    (req_sym),
      .req_last   (req_last),
      .req_ready  (req_ready),
      .grant      (grant),
      .rec_sym    (rec_sym),
      .rec_en     (rec_en),
      .rec_clear  (rec_clear),
      .rec_match  (rec_match),
      .done       (done),
      .done_id    (done_id),
      .done_count (done_count),
      .done_abort (done_abort)
   );

   always #5 clock = ~clock;

   // Recogniser model: matches the symbol pair 01,01.
   logic [1:0] rstate;
   always @(posedge clock) begin
      if (!reset_n || rec_clear) rstate <= 2'b00;
      else if (rec_en)           rstate <= rec_sym;
   end
   assign rec_match = (rstate == 2'b01) && (rec_sym == 2'b01);

   int         cyc = 0, en_cnt = 0, last_en_cyc = 0, done_cyc = 0, done_seen = 0;
   logic [1:0] glog[$];
   int         clog[$];
   int         did_log[$];
   int         dcnt_log[$];

   always @(negedge clock) begin
      cyc = cyc + 1;
      if (rec_en) begin
         en_cnt      = en_cnt + 1;
         last_en_cyc = cyc;
      end
      if (rec_clear) begin
         glog.push_back(grant);
         clog.push_back(cyc);
      end
      if (done) begin
         done_seen = done_seen + 1;
         done_cyc  = cyc;
         did_log.push_back(int'(done_id));
         dcnt_log.push_back(int'(done_count));
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_sym   = '0;
      step(2);
      reset_n = 1'b1;
   endtask

   task automatic clear_logs();
      en_cnt    = 0;
      done_seen = 0;
      glog.delete();
      clog.delete();
      did_log.delete();
      dcnt_log.delete();
   endtask

   // Drives one packet from requester id; optional stall after stall_at accepted symbols.
   task automatic send_pkt(input int id, input logic [31:0] syms, input int len,
                           input int stall_at, input int stall_len, input bit use_last);
      int k, budget;
      k = 0;
      budget = 0;
      while (k < len && budget < 200) begin
         req_valid[id]        = 1'b1;
         req_sym[2*id +: 2]   = syms[2*k +: 2];
         req_last[id]         = use_last && (k == len - 1);
         @(negedge clock);
         if (req_ready[id]) k++;
         step(1);
         budget++;
         if (k == stall_at && stall_len > 0) begin
            req_valid[id] = 1'b0;
            req_last[id]  = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               @(negedge clock);
               check_val("stall_rec_en", rec_en, 0);
               step(1);
            end
            stall_at = -1;
         end
      end
      req_valid[id] = 1'b0;
      req_last[id]  = 1'b0;
      check_val("send_accepted", k, len);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pos[2];
      int seen_at;
      logic [31:0] sat_syms;

      // Reset with both requesters valid.
      reset_n   = 1'b0;
      req_valid = 2'b11;
      req_sym   = '0;
      req_last  = '0;
      step(3);
      @(negedge clock);
      check_val("rst_grant", grant, 2'b00);
      check_val("rst_ready", req_ready, 2'b00);
      check_val("rst_rec_en", rec_en, 0);
      check_val("rst_done", done, 0);
      check_val("rst_done_count", done_count, 0);
      reset_n = 1'b1;
      @(negedge clock);
      check_val("rel_grant", grant, 2'b01);
      check_val("rel_ready_clear", req_ready, 2'b00);
      check_val("rel_rec_clear", rec_clear, 1);
      req_valid = 2'b00;
      @(negedge clock);
      check_val("rel_ready", req_ready, 2'b01);
      step(1);

      // Single packet req0: 00,01,01.
      do_reset();
      clear_logs();
      send_pkt(0, 32'h14, 3, -1, 0, 1'b1);
      step(2);
      check_val("pkt_rec_en_cycles", en_cnt, 3);
      check_val("pkt_done_seen", done_seen, 1);
      check_val("pkt_done_latency", done_cyc - last_en_cyc, 1);
      check_val("pkt_done_id", done_id, 0);
      check_val("pkt_done_count", done_count, 1);
      check_val("pkt_done_abort", done_abort, 0);
      check_val("pkt_grant_idle", grant, 2'b00);

      // One-symbol packet: 01 right after clear gives no match.
      clear_logs();
      send_pkt(0, 32'h1, 1, -1, 0, 1'b1);
      step(2);
      check_val("one_rec_en_cycles", en_cnt, 1);
      check_val("one_done_count", done_count, 0);
      check_val("one_done_seen", done_seen, 1);

      // Contention: both always valid, 2-symbol packets.
      do_reset();
      clear_logs();
      pos[0]    = 0;
      pos[1]    = 0;
      req_sym   = 4'b0001;
      req_valid = 2'b11;
      for (int c = 0; c < 20; c++) begin
         req_last[0] = (pos[0] == 1);
         req_last[1] = (pos[1] == 1);
         @(negedge clock);
         for (int i = 0; i < 2; i++)
            if (req_ready[i]) pos[i] = (pos[i] == 1) ? 0 : 1;
         step(1);
      end
      req_valid = 2'b00;
      req_last  = 2'b00;
      check_val("cont_npkts", glog.size() >= 4, 1);
      if (glog.size() >= 4 && did_log.size() >= 2) begin
         check_val("cont_g0", glog[0], 2'b01);
         check_val("cont_g1", glog[1], 2'b10);
         check_val("cont_g2", glog[2], 2'b01);
         check_val("cont_g3", glog[3], 2'b10);
         check_val("cont_period01", clog[1] - clog[0], 5);
         check_val("cont_period23", clog[3] - clog[2], 5);
         check_val("cont_id0", did_log[0], 0);
         check_val("cont_id1", did_log[1], 1);
         check_val("cont_cnt0", dcnt_log[0], 1);
         check_val("cont_cnt1", dcnt_log[1], 0);
      end

      // Stall after the second symbol.
      do_reset();
      clear_logs();
`ifdef FSM_ARB_TIMEOUT_EN
      send_pkt(0, 32'h14, 3, 2, 3, 1'b1);
`else
      send_pkt(0, 32'h14, 3, 2, 5, 1'b1);
`endif
      step(2);
      check_val("stall_rec_en_cycles", en_cnt, 3);
      check_val("stall_done_count", done_count, 1);
      check_val("stall_done_abort", done_abort, 0);

      // Saturation: five repeats of 00,01,01 from req1 on a 2-bit counter.
      clear_logs();
      sat_syms = '0;
      for (int j = 0; j < 5; j++) sat_syms[6*j +: 6] = 6'b010100;
      send_pkt(1, sat_syms, 15, -1, 0, 1'b1);
      step(2);
      check_val("sat_done_count", done_count, 3);
      check_val("sat_done_id", done_id, 1);
      check_val("sat_done_seen", done_seen, 1);

      // Packet that never delivers its last symbol.
      do_reset();
      clear_logs();
      send_pkt(0, 32'h14, 3, -1, 0, 1'b0);
      seen_at = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (done && seen_at < 0) seen_at = i;
         step(1);
      end
`ifdef FSM_ARB_TIMEOUT_EN
      check_val("to_done_delay", seen_at, 4);
      check_val("to_done_abort", done_abort, 1);
      check_val("to_done_count", done_count, 1);
      check_val("to_done_id", done_id, 0);
`else
      check_val("nto_no_done", seen_at, 32'hFFFF_FFFF);
      check_val("nto_ready_held", req_ready, 2'b01);
      check_val("nto_done_abort", done_abort, 0);
`endif
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fsm_abb_arbiter.md
Name: fsm_abb_arbiter

Overview:
- Round-robin controller that shares one 2-bit-symbol pattern recogniser between NREQ requesters.
- The recogniser is our Mealy sequence-detector datapath in its enable/clear variant: state register with enable, plus a clear-to-00 input.
- Grants one requester for a whole packet, clears the recogniser before the first symbol, and gates its state enable per accepted symbol.
- Counts matches (rec_match) per packet and reports the count, the requester id and a done pulse.

Parameters:
- NREQ, 2, number of requesters (2..8).
- CNT_W, 8, width of the per-packet match counter.
- TIMEOUT, 16, stall cycles before abort; used only with FSM_ARB_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester symbol valid.
- req_sym  in  2*NREQ  per-requester symbol; requester i on bits [2i+1:2i].
- req_last  in  NREQ  marks the last symbol of a packet.
- req_ready  out  NREQ  symbol accepted; at most one bit high.
- grant  out  NREQ  one-hot owner of the recogniser; 0 when idle.
- rec_sym  out  2  symbol driven to the recogniser.
- rec_en  out  1  recogniser state-register enable.
- rec_clear  out  1  forces recogniser state to 00.
- rec_match  in  1  recogniser Mealy output (combinational of state and rec_sym).
- done  out  1  one-cycle packet-complete pulse.
- done_id  out  $clog2(NREQ)  index of the finished requester; held until the next done.
- done_count  out  CNT_W  matches in the finished packet; held until the next done.
- done_abort  out  1  packet ended by timeout; held with done_id; tied 0 without the macro.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state=IDLE; grant, req_ready, rec_en, rec_clear, done, done_id, done_count, done_abort, count all 0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - Reset mid-packet aborts silently: no done.
- IDLE:
  - If any req_valid is high, pick the first valid requester starting at last_grant+1 (wrapping), register the one-hot grant, go to CLEAR.
  - req_ready=0, rec_en=0, rec_sym=00.
- CLEAR (one cycle):
  - rec_clear=1, rec_en=0, req_ready=0, count cleared; go to STREAM.
- STREAM:
  - req_ready=grant; rec_sym = symbol of the granted requester.
  - beat = req_valid[g] & req_ready[g]; rec_en=beat.
  - On each beat with rec_match=1: count+1, saturating at 2^CNT_W-1.
  - beat with req_last[g]: go to REPORT; the match on the last symbol is counted.
  - No beat: hold state; the recogniser holds because rec_en=0. Non-granted valids are ignored.
- REPORT (one cycle):
  - done=1; done_id=g; done_count=count (including a match on the last beat); done_abort=0.
  - last_grant=g, grant cleared; go to IDLE.
- Latency and throughput:
  - Valid seen in IDLE at cycle t: grant at t+1, ready at t+2.
  - done one cycle after the last beat.
  - Minimum per-packet occupancy: 3 + packet length cycles.
- Input rules:
  - req_sym and req_last are sampled only on a beat.
  - A requester may drop valid mid-packet; the block waits indefinitely.
  - req_last on the first beat gives a one-symbol packet.

Optional Feature:
- FSM_ARB_TIMEOUT_EN defined:
  - A stall counter in STREAM resets on each beat.
  - When it reaches TIMEOUT consecutive no-beat cycles, go to REPORT with done_abort=1 and done_count = matches so far.
- Undefined: no stall counter; done_abort constant 0; stalls wait forever.

Decomposition:
- Package fsm_arb_pkg: state enum {IDLE, CLEAR, STREAM, REPORT}, SYM_W=2, reset constant for last_grant.
- Sub-module rr_picker: combinational round-robin one-hot picker; inputs req_valid and last_grant, outputs one-hot and index.

Test Plan:
- Reset: reset_n low 3 cycles with req_valid=11 -> grant=00, req_ready=00, rec_en=0, done=0. Release -> grant=01 next cycle, ready=01 the cycle after.
- Single packet, req0, symbols 00,01,01(last), no stalls -> rec_en high exactly 3 cycles; done one cycle after the last beat with done_id=0, done_count=1.
- Contention: both requesters always valid, 2-symbol packets -> grant sequence 01,10,01,10; each packet occupies 5 cycles.
- Stall: req0 drops valid for 5 cycles after symbol 2 of 00,01,01 -> rec_en=0 during the stall; after resume, match still counted, done_count=1.
- Saturation: CNT_W=2, req1 sends 00,01,01 repeated 5 times -> done_count=3, done_id=1.
- Timeout: with FSM_ARB_TIMEOUT_EN and TIMEOUT=4, req0 sends 00,01,01 and then drops valid -> done after 4 stall cycles with done_abort=1, done_count=1. Without the macro -> no done.
